priority_aging_unit: RTL and testbench
======================================

# priority_aging_unit

Sequential front-end for the combinational linear dynamic-priority arbiter. It owns the per-requester priority registers that drive the arbiter's `prt` inputs and ages waiting requesters toward urgency so none starve. It captures the arbiter's combinational grant into a registered grant held until the consumer acknowledges, then demotes the served requester to the lowest urgency.

## Interface
- `N`, default 4: number of requesters. Must be a power of two, ≥2.
- `AGE_PERIOD`, default 8: cycles between aging steps, ≥1.
- `W`, derived as `$clog2(N)`: width of priority and index values.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_in`  in  N  request vector, also wired directly to the arbiter's `req`.
- `prt_out`  out  W × N (unpacked `[N-1:0]`)  priority per requester, to the arbiter's `prt`. Lower value means more urgent.
- `arb_grant`  in  W  arbiter's `grant`.
- `arb_valid`  in  1  arbiter's `valid`.
- `grant_ack`  in  1  consumer accepts the held grant.
- `grant_idx`  out  W  registered granted index.
- `grant_valid`  out  1  `grant_idx` is valid and held.

## Operation
- Priority registers `prio[i]`, width W. `prt_out[i] = prio[i]` directly, with no extra delay.
- FSM has two states, IDLE and HOLD.
  - IDLE:
    - If `arb_valid=1`: `grant_idx <= arb_grant`, `grant_valid <= 1`, go to HOLD.
    - Otherwise stay in IDLE.
    - `grant_ack` is ignored in IDLE.
  - HOLD:
    - `grant_idx` and `grant_valid` are frozen. `arb_grant` is ignored.
    - If `grant_ack=1`: `prio[grant_idx] <= N-1`, `grant_valid <= 0`, go to IDLE.
    - Deassertion of the held requester's `req_in` does not cancel the grant. Only `grant_ack` or `rst` ends HOLD.
- Age counter `age_cnt`:
  - Free-running, counts 0..AGE_PERIOD-1 and wraps to 0.
  - `age_tick = (age_cnt == AGE_PERIOD-1)`.
  - With `AGE_PERIOD=1`, `age_tick` is constantly 1.
- Aging on each `age_tick` cycle, for every i:
  - If `req_in[i]=1` and `prio[i]>0`: `prio[i] <= prio[i]-1`.
  - Saturates at 0 and never wraps.
  - If `req_in[i]=0`, `prio[i]` is unchanged.
  - The index currently held in HOLD (`grant_valid=1`, `i==grant_idx`) does not age.
- Priority of simultaneous events on one `prio[i]`:
  - Ack demotion to N-1 beats aging.
  - No other writers exist.
- Arithmetic: all priority values are unsigned W-bit. N-1 fits in W bits because N is a power of two.

## Timing
- Reset values (asserted asynchronously, held while `rst=1`):
  - `prio[i] = i`, so `prt_out[0]=0 … prt_out[N-1]=N-1`.
  - `grant_valid=0`, `grant_idx=0`, FSM in IDLE, `age_cnt=0`.
- Grant latency: `arb_valid=1` sampled at edge t gives `grant_valid=1` and `grant_idx` valid after edge t, i.e. one cycle.
- Release: `grant_ack` sampled at edge t gives `grant_valid=0` and the new `prio` value visible after edge t.
- Back-to-back grants:
  - Each grant leaves one IDLE cycle, so the minimum grant period is 2 cycles.
  - The IDLE cycle after an ack sees the updated `prt_out`, so the arbiter's next choice reflects the demotion.
- Aging cadence: a continuously requesting, never-granted requester reaches 0 after at most `(N-1)·AGE_PERIOD` cycles from reset.
- `rst` mid-HOLD:
  - `grant_valid` drops immediately, without waiting for a clock edge.
  - All priorities return to reset values. No ack is implied.
- First edge after `rst` release: normal operation, `age_cnt` counting from 0.

## Test plan
All scenarios use N=4, AGE_PERIOD=4, with the real arbiter instance connected.

- Reset: assert `rst` -> `prt_out = {3,2,1,0}` (index 3..0), `grant_valid=0`, `grant_idx=0`. Repeat the check with `rst` asserted between clock edges; outputs must change without a clock edge.
- Single request: `req_in=4'b0100` in IDLE -> next cycle `grant_idx=2`, `grant_valid=1`. The held grant persists for 3 cycles without ack. Ack on cycle 4 -> next cycle `grant_valid=0`, `prt_out[2]=3`.
- Aging and saturation:
  - Setup: `req_in=4'b1001`, grant index 0 and withhold ack.
  - Expect `prio[3]` to step 3→2→1→0 on successive ticks (every 4 cycles), then stay at 0.
  - `prio[0]` stays unchanged while held.
- Ack/tick collision: ack index 3 on the same cycle as `age_tick` with `req_in[3]=1` -> `prt_out[3]=3`, not 2.
- Fairness rotation: `req_in=4'b1111` held, ack every cycle it is allowed -> the first four grants cover all indices 0..3 once each. No index is granted twice before all four have been served.
- Spurious ack and reset mid-HOLD:
  - `grant_ack=1` in IDLE with `req_in=0` -> no change to `prio` or `grant_valid`.
  - `rst` during HOLD -> `grant_valid=0` immediately and `prio` restored to `{3,2,1,0}`.

Source files
------------

// File: rtl/priority_aging_unit.sv
// rtl/priority_aging_unit.sv - registered grant holder and aging priority table
// feeding a combinational dynamic-priority arbiter.
module priority_aging_unit #(
    parameter int N          = 4,
    parameter int AGE_PERIOD = 8,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [W-1:0] prt_out [N-1:0],
    input  logic [W-1:0] arb_grant,
    input  logic         arb_valid,
    input  logic         grant_ack,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    localparam int             AW       = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    localparam logic [AW-1:0]  AGE_LAST = AW'(AGE_PERIOD - 1);
    localparam logic [W-1:0]   PRIO_LOW = W'(N - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  grant_idx_q, grant_idx_d;
    logic [W-1:0]  prio_q [N-1:0];
    logic [W-1:0]  prio_d [N-1:0];
    logic [AW-1:0] age_cnt_q, age_cnt_d;
    logic          age_tick;

    assign age_tick = (age_cnt_q == AGE_LAST);

    always_comb begin
        age_cnt_d = age_tick ? '0 : age_cnt_q + AW'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        prio_d      = prio_q;

        // The held requester is frozen so it cannot climb while already being served.
        for (int i = 0; i < N; i++) begin
            if (age_tick && req_in[i] && (prio_q[i] != '0) &&
                !((state_q == HOLD) && (grant_idx_q == W'(i)))) begin
                prio_d[i] = prio_q[i] - W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_idx_d = arb_grant;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // Demotion is applied after aging so it overrides a same-cycle tick.
                if (grant_ack) begin
                    prio_d[grant_idx_q] = PRIO_LOW;
                    state_d             = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            age_cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                prio_q[i] <= W'(i);
            end
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            age_cnt_q   <= age_cnt_d;
            prio_q      <= prio_d;
        end
    end

    assign prt_out     = prio_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = (state_q == HOLD);

endmodule

// File: tb/tb_priority_aging_unit.sv
// tb/tb_priority_aging_unit.sv - directed checks of priority_aging_unit with a
// lowest-value-wins arbiter model closing the loop.
module tb_priority_aging_unit;

    logic       clk;
    logic       rst;
    logic [3:0] req_in;
    logic [1:0] prt_out [3:0];
    logic [1:0] arb_grant;
    logic       arb_valid;
    logic       grant_ack;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int checks;
    int errors;

    priority_aging_unit #(
        .N(4),
        .AGE_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .prt_out(prt_out),
        .arb_grant(arb_grant),
        .arb_valid(arb_valid),
        .grant_ack(grant_ack),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid)
    );

    // Linear arbiter: smallest priority value wins, ties go to the lowest index.
    logic [1:0] best;
    always_comb begin
        arb_valid = 1'b0;
        arb_grant = 2'd0;
        best      = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (req_in[i] && (!arb_valid || (prt_out[i] < best))) begin
                arb_valid = 1'b1;
                arb_grant = 2'(i);
                best      = prt_out[i];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_prt(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_prt0"}, 32'(prt_out[0]), 32'(e0));
        chk({tag, "_prt1"}, 32'(prt_out[1]), 32'(e1));
        chk({tag, "_prt2"}, 32'(prt_out[2]), 32'(e2));
        chk({tag, "_prt3"}, 32'(prt_out[3]), 32'(e3));
    endtask

    task automatic chk_grant(input string tag, input int gv, input int idx);
        chk({tag, "_gv"}, 32'(grant_valid), 32'(gv));
        chk({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts rst between edges, checks the asynchronous effect, releases after one edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_prt(tag, 0, 1, 2, 3);
        chk_grant(tag, 0, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_in    = 4'b0000;
        grant_ack = 1'b0;

        #2;
        chk_prt("reset", 0, 1, 2, 3);
        chk_grant("reset", 0, 0);
        step();
        step();
        rst = 1'b0;

        // Single request, held three cycles, then acked on a tick edge.
        req_in = 4'b0100;
        step();
        chk_grant("single_e1", 1, 2);
        req_in = 4'b0000;
        step();
        chk_grant("single_e2", 1, 2);
        step();
        chk_grant("single_e3", 1, 2);
        grant_ack = 1'b1;
        step();
        chk_grant("single_ack", 0, 2);
        chk_prt("single_ack", 0, 1, 3, 3);
        step();
        chk("spurious_gv", 32'(grant_valid), 32'd0);
        chk_prt("spurious", 0, 1, 3, 3);
        grant_ack = 1'b0;

        do_reset("rst_between");

        // Aging with index 0 held and no ack.
        req_in = 4'b1001;
        step();
        chk_grant("age_e1", 1, 0);
        step();
        step();
        chk("age_e3_prt3", 32'(prt_out[3]), 32'd3);
        step();
        chk("age_e4_prt3", 32'(prt_out[3]), 32'd2);
        chk("age_e4_prt0", 32'(prt_out[0]), 32'd0);
        repeat (4) step();
        chk("age_e8_prt3", 32'(prt_out[3]), 32'd1);
        repeat (4) step();
        chk("age_e12_prt3", 32'(prt_out[3]), 32'd0);
        repeat (4) step();
        chk_prt("age_e16", 0, 1, 2, 0);
        chk_grant("age_e16", 1, 0);
        grant_ack = 1'b1;
        step();
        chk_grant("age_ack", 0, 0);
        chk("age_ack_prt0", 32'(prt_out[0]), 32'd3);
        grant_ack = 1'b0;
        req_in    = 4'b0000;

        do_reset("rst_after_age");

        // Held index does not age across a tick; ack on a later tick wins over aging.
        req_in = 4'b1000;
        step();
        chk_grant("coll_e1", 1, 3);
        repeat (3) step();
        chk("coll_held_prt3", 32'(prt_out[3]), 32'd3);
        chk_grant("coll_held", 1, 3);
        repeat (3) step();
        grant_ack = 1'b1;
        step();
        chk("coll_ack_gv", 32'(grant_valid), 32'd0);
        chk("coll_ack_prt3", 32'(prt_out[3]), 32'd3);
        grant_ack = 1'b0;
        req_in    = 4'b0000;

        do_reset("rst_after_coll");

        // Fairness rotation with all requesting and ack held high.
        step();
        step();
        req_in    = 4'b1111;
        grant_ack = 1'b1;
        step();
        chk_grant("fair_g0", 1, 0);
        step();
        step();
        chk_grant("fair_g1", 1, 1);
        step();
        step();
        chk_grant("fair_g2", 1, 2);
        step();
        chk_prt("fair_e8", 2, 2, 3, 1);
        grant_ack = 1'b0;
        step();
        chk_grant("fair_g3", 1, 3);

        // Reset in the middle of HOLD.
        #2;
        rst = 1'b1;
        #1;
        chk_grant("rst_hold", 0, 0);
        chk_prt("rst_hold", 0, 1, 2, 3);
        step();
        rst    = 1'b0;
        req_in = 4'b0000;
        step();
        chk_grant("post_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
